// File: rtl/spi_lcd_pkg.sv
// Shared types for the LCD SPI receive path: byte width, the decoded-byte
// record carried through the FIFO, and the receiver FSM states.
package spi_lcd_pkg;

    localparam int BYTE_W = 8;

    // One decoded byte plus the register-select level captured with it
    typedef struct packed {
        logic              is_data;
        logic [BYTE_W-1:0] data;
    } lcd_byte_t;

    typedef enum logic {
        IDLE,
        SHIFT
    } rx_state_t;

endpackage

// File: rtl/spi_lcd_rx_fifo.sv
// Synchronous FIFO of decoded LCD bytes. Pointers carry one extra wrap bit
// so full and empty are distinguished without a separate counter. A push
// while full is accepted only when a pop frees the head in the same cycle.
module spi_lcd_rx_fifo
    import spi_lcd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  lcd_byte_t din,
    input  logic      pop,
    output lcd_byte_t dout,
    output logic      empty,
    output logic      full
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    lcd_byte_t       mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    // Status flags and accepted operations, all from registered pointers
    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        dout    = mem[rd_ptr[AW-1:0]];
    end

    // Storage and pointer update; storage is cleared so the head reads zero after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/spi_lcd_rx.sv
// LCD SPI receiver: oversamples lcd_clk/lcd_cs/lcd_rs/lcd_data in the system
// clock domain, rebuilds MSB-first bytes on lcd_clk rising edges and queues
// them with their register-select bit for a valid/ready consumer.
//
// Output stream: a byte transfers on every clk edge where rx_valid and
// rx_ready are both high; rx_data/rx_is_data hold while rx_valid is high and
// rx_ready is low. rx_valid never depends on rx_ready.
module spi_lcd_rx
    import spi_lcd_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lcd_resetn,
    input  logic             lcd_clk,
    input  logic             lcd_cs,
    input  logic             lcd_rs,
    input  logic             lcd_data,
    output logic [7:0]       rx_data,
    output logic             rx_is_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             frame_err,
    output logic             overflow,
    output logic [CNT_W-1:0] byte_cnt
);

    logic [SYNC_STAGES-1:0] clk_sync, cs_sync, rs_sync, data_sync, rstn_sync;
    logic                   clk_s, cs_s, rs_s, data_s, rstn_s;
    logic                   clk_d, cs_d;
    logic                   clk_rise, cs_rise;

    rx_state_t              state, state_n;
    logic [2:0]             bitcnt, bitcnt_n;
    logic [BYTE_W-1:0]      shift_reg, shift_n;
    logic                   byte_done, fe_n;

    logic                   push_q;
    lcd_byte_t              push_byte;
    lcd_byte_t              head;
    logic                   fifo_empty, fifo_full;

    // Synchronizer chains plus one edge-detect register; reset loads idle line levels
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= '0;
            cs_sync   <= '1;
            rs_sync   <= '0;
            data_sync <= '0;
            rstn_sync <= '1;
            clk_d     <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], lcd_clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], lcd_cs};
            rs_sync   <= {rs_sync[SYNC_STAGES-2:0], lcd_rs};
            data_sync <= {data_sync[SYNC_STAGES-2:0], lcd_data};
            rstn_sync <= {rstn_sync[SYNC_STAGES-2:0], lcd_resetn};
            clk_d     <= clk_s;
            cs_d      <= cs_s;
        end
    end

    // Synced levels and edge strobes
    always_comb begin
        clk_s    = clk_sync[SYNC_STAGES-1];
        cs_s     = cs_sync[SYNC_STAGES-1];
        rs_s     = rs_sync[SYNC_STAGES-1];
        data_s   = data_sync[SYNC_STAGES-1];
        rstn_s   = rstn_sync[SYNC_STAGES-1];
        clk_rise = clk_s && !clk_d;
        cs_rise  = cs_s && !cs_d;
    end

    // FSM state, bit counter and shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bitcnt    <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_n;
            bitcnt    <= bitcnt_n;
            shift_reg <= shift_n;
        end
    end

    // Next-state: shift on lcd_clk rises, emit on the 8th, flag partial bytes on CS release
    always_comb begin
        state_n   = state;
        bitcnt_n  = bitcnt;
        shift_n   = shift_reg;
        byte_done = 1'b0;
        fe_n      = 1'b0;
        case (state)
            IDLE: begin
                if (rstn_s && !cs_s) begin
                    state_n  = SHIFT;
                    bitcnt_n = '0;
                end
            end
            SHIFT: begin
                if (!rstn_s) begin
                    // Panel reset silently abandons any partial byte
                    state_n  = IDLE;
                    bitcnt_n = '0;
                end else begin
                    if (clk_rise) begin
                        shift_n  = {shift_reg[BYTE_W-2:0], data_s};
                        bitcnt_n = bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            byte_done = 1'b1;
                            bitcnt_n  = '0;
                        end
                    end
                    if (cs_rise) begin
                        state_n  = IDLE;
                        bitcnt_n = '0;
                        fe_n     = (bitcnt != 3'd0) && !byte_done;
                    end
                end
            end
            default: begin
                state_n  = IDLE;
                bitcnt_n = '0;
            end
        endcase
    end

    // Register the push request and frame error so every output comes from a flop
    always_ff @(posedge clk) begin
        if (rst) begin
            push_q    <= 1'b0;
            push_byte <= '0;
            frame_err <= 1'b0;
        end else begin
            push_q            <= byte_done;
            push_byte.is_data <= rs_s;
            push_byte.data    <= shift_n;
            frame_err         <= fe_n;
        end
    end

    // Byte counter counts every push request; overflow latches on a dropped byte
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= '0;
            overflow <= 1'b0;
        end else if (push_q) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
            if (fifo_full && !rx_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    spi_lcd_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_q),
        .din   (push_byte),
        .pop   (rx_ready),
        .dout  (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Stream outputs from the FIFO head
    always_comb begin
        rx_data    = head.data;
        rx_is_data = head.is_data;
        rx_valid   = !fifo_empty;
    end

endmodule

// File: tb/tb_spi_lcd_rx.sv
// Directed bench for spi_lcd_rx: drives SPI frames at a 200 ns SPI period,
// collects accepted bytes and compares against hand-written expected bytes.
module tb_spi_lcd_rx;

    logic        clk;
    logic        rst;
    logic        lcd_resetn;
    logic        lcd_clk;
    logic        lcd_cs;
    logic        lcd_rs;
    logic        lcd_data;
    logic [7:0]  rx_data;
    logic        rx_is_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        frame_err;
    logic        overflow;
    logic [15:0] byte_cnt;

    int          vectors;
    int          miscompares;
    int          fe_cnt;
    int          fe_base;
    int          cap_rd;
    logic [8:0]  cap_q[$];
    logic [8:0]  exp_q[$];

    spi_lcd_rx #(
        .SYNC_STAGES (2),
        .FIFO_DEPTH  (4),
        .CNT_W       (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .lcd_resetn (lcd_resetn),
        .lcd_clk    (lcd_clk),
        .lcd_cs     (lcd_cs),
        .lcd_rs     (lcd_rs),
        .lcd_data   (lcd_data),
        .rx_data    (rx_data),
        .rx_is_data (rx_is_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .byte_cnt   (byte_cnt)
    );

    // Clock and reset: 100 MHz system clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Collector: record each accepted byte and count frame_err cycles on the falling edge
    initial fe_cnt = 0;
    always @(negedge clk) begin
        if (!rst && rx_valid && rx_ready) cap_q.push_back({rx_is_data, rx_data});
        if (frame_err) fe_cnt++;
    end

    // Advance n clock cycles, landing just after the rising edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One SPI bit: 10 cycles low with data set up, 10 cycles high
    task automatic spi_bit(input logic b);
        lcd_data = b;
        tick(10);
        lcd_clk = 1'b1;
        tick(10);
        lcd_clk = 1'b0;
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] b);
        lcd_rs = rs;
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    endtask

    task automatic cs_begin();
        lcd_cs = 1'b0;
        tick(5);
    endtask

    task automatic cs_end();
        tick(10);
        lcd_cs = 1'b1;
        tick(10);
    endtask

    // Compare newly collected bytes against the expected queue
    task automatic check_stream(input string tag);
        check({tag, "_count"}, 32'(cap_q.size() - cap_rd), 32'(exp_q.size()));
        while (exp_q.size() > 0) begin
            logic [8:0] e;
            e = exp_q.pop_front();
            check(tag, 32'(cap_q[cap_rd]), 32'(e));
            cap_rd++;
        end
        cap_rd = cap_q.size();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cap_rd      = 0;
        rst         = 1'b1;
        lcd_resetn  = 1'b1;
        lcd_clk     = 1'b0;
        lcd_cs      = 1'b1;
        lcd_rs      = 1'b0;
        lcd_data    = 1'b0;
        rx_ready    = 1'b0;
        tick(4);

        // Reset state
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_data", 32'(rx_data), 32'h00);
        check("rst_is_data", 32'(rx_is_data), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_byte_cnt", 32'(byte_cnt), 32'd0);
        rst = 1'b0;
        tick(5);

        // Command byte 0x2A
        fe_base  = fe_cnt;
        rx_ready = 1'b1;
        cs_begin();
        send_byte(1'b0, 8'h2A);
        cs_end();
        exp_q.push_back(9'h02A);
        check_stream("cmd");
        check("cmd_byte_cnt", 32'(byte_cnt), 32'd1);
        check("cmd_no_fe", 32'(fe_cnt - fe_base), 32'd0);

        // Data burst under one CS (byte_cnt is cumulative)
        cs_begin();
        send_byte(1'b1, 8'hA5);
        send_byte(1'b1, 8'h3C);
        send_byte(1'b1, 8'hFF);
        cs_end();
        exp_q.push_back(9'h1A5);
        exp_q.push_back(9'h13C);
        exp_q.push_back(9'h1FF);
        check_stream("burst");
        check("burst_byte_cnt", 32'(byte_cnt), 32'd4);

        // Partial frame: 5 bits of 0xB0, then a full 0x11
        fe_base = fe_cnt;
        cs_begin();
        lcd_rs = 1'b0;
        spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1); spi_bit(1'b1); spi_bit(1'b0);
        cs_end();
        check("partial_fe_width", 32'(fe_cnt - fe_base), 32'd1);
        check_stream("partial");
        check("partial_byte_cnt", 32'(byte_cnt), 32'd4);
        cs_begin();
        send_byte(1'b0, 8'h11);
        cs_end();
        exp_q.push_back(9'h011);
        check_stream("after_partial");
        check("after_partial_cnt", 32'(byte_cnt), 32'd5);
        check("after_partial_fe", 32'(fe_cnt - fe_base), 32'd1);

        // Overflow: five bytes into a four-entry FIFO with no consumer
        rx_ready = 1'b0;
        cs_begin();
        send_byte(1'b1, 8'h01);
        send_byte(1'b1, 8'h02);
        send_byte(1'b1, 8'h03);
        send_byte(1'b1, 8'h04);
        tick(5);
        check("ovf_not_yet", 32'(overflow), 32'd0);
        send_byte(1'b1, 8'h05);
        cs_end();
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_byte_cnt", 32'(byte_cnt), 32'd10);
        check("ovf_head_valid", 32'(rx_valid), 32'd1);
        check("ovf_head_data", 32'(rx_data), 32'h01);
        check("ovf_head_is_data", 32'(rx_is_data), 32'd1);
        rx_ready = 1'b1;
        tick(6);
        rx_ready = 1'b0;
        exp_q.push_back(9'h101);
        exp_q.push_back(9'h102);
        exp_q.push_back(9'h103);
        exp_q.push_back(9'h104);
        check_stream("drain");
        check("drain_empty", 32'(rx_valid), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Panel reset mid-byte: 3 bits of 0x7E lost, edges while in reset ignored
        fe_base  = fe_cnt;
        rx_ready = 1'b1;
        cs_begin();
        lcd_rs = 1'b1;
        spi_bit(1'b0); spi_bit(1'b1); spi_bit(1'b1);
        lcd_resetn = 1'b0;
        tick(5);
        spi_bit(1'b1); spi_bit(1'b1);
        lcd_resetn = 1'b1;
        tick(10);
        send_byte(1'b0, 8'h55);
        cs_end();
        exp_q.push_back(9'h055);
        check_stream("resetn");
        check("resetn_no_fe", 32'(fe_cnt - fe_base), 32'd0);
        check("resetn_byte_cnt", 32'(byte_cnt), 32'd11);

        // System reset mid-byte with two bytes queued
        rx_ready = 1'b0;
        cs_begin();
        send_byte(1'b0, 8'h10);
        send_byte(1'b0, 8'h20);
        spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1);
        check("pre_rst_valid", 32'(rx_valid), 32'd1);
        check("pre_rst_byte_cnt", 32'(byte_cnt), 32'd13);
        rst = 1'b1;
        tick(1);
        check("mid_rst_valid", 32'(rx_valid), 32'd0);
        check("mid_rst_byte_cnt", 32'(byte_cnt), 32'd0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        check("mid_rst_data", 32'(rx_data), 32'h00);
        rst    = 1'b0;
        lcd_cs = 1'b1;
        tick(10);
        fe_base  = fe_cnt;
        rx_ready = 1'b1;
        cs_begin();
        send_byte(1'b1, 8'hC3);
        cs_end();
        exp_q.push_back(9'h1C3);
        check_stream("post_rst");
        check("post_rst_byte_cnt", 32'(byte_cnt), 32'd1);
        check("post_rst_no_fe", 32'(fe_cnt - fe_base), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
